ifetch_prefetch: RTL and testbench

IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

---
 rtl/ifetch_prefetch.sv | 105 ++++++++++
 tb/tb_ifetch_prefetch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// rtl/ifetch_prefetch.sv - instruction prefetch unit with credit-limited iBus fetch and redirect flush
module ifetch_prefetch #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        iBus_cmd_valid,
    input  logic        iBus_cmd_ready,
    output logic [31:0] iBus_cmd_payload_pc,
    input  logic        iBus_rsp_valid,
    input  logic [31:0] iBus_rsp_instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] oPC,
    input  logic        branchTaken,
    input  logic [31:0] aluPC
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic          r_run;
    logic [CW-1:0] r_queued;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];

    logic          w_credit;
    logic          w_fire;
    logic          w_pop;
    logic          w_push;
    logic          w_drop_rsp;
    logic [31:0]   w_target;
    logic          w_unused_ok;

    // Credit covers both queued and in-flight entries so a response always finds a free slot.
    assign w_credit   = (({1'b0, r_queued} + {1'b0, r_outst}) < (CW + 1)'(DEPTH))
                        && (r_outst < CW'(MAX_OUTSTANDING));
    assign iBus_cmd_valid      = r_run && w_credit && !branchTaken;
    assign iBus_cmd_payload_pc = r_pc;
    assign w_fire     = iBus_cmd_valid && iBus_cmd_ready;
    assign w_pop      = instr_valid && instr_ready;
    assign w_drop_rsp = iBus_rsp_valid && (r_drop != '0);
    assign w_push     = iBus_rsp_valid && (r_drop == '0) && !branchTaken;
    assign w_target   = {aluPC[31:2], 2'b00};
    assign w_unused_ok = &{1'b0, aluPC[1:0]};

    assign instr_valid = (r_queued != '0);
    assign instr       = instr_valid ? r_mem_instr[r_head] : 32'h0;
    assign oPC         = instr_valid ? r_mem_pc[r_head]    : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_run    <= 1'b0;
            r_queued <= '0;
            r_outst  <= '0;
            r_drop   <= '0;
            r_head   <= '0;
            r_tail   <= '0;
        end else begin
            r_run   <= 1'b1;
            r_outst <= r_outst + CW'(w_fire) - CW'(iBus_rsp_valid);
            if (branchTaken) begin
                // Everything still in flight belongs to the old stream; a response this cycle is already discarded.
                r_pc     <= w_target;
                r_rsp_pc <= w_target;
                r_drop   <= r_outst - CW'(iBus_rsp_valid);
                r_queued <= '0;
                r_head   <= '0;
                r_tail   <= '0;
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_drop_rsp) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_push) begin
                    r_tail   <= r_tail + AW'(1);
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                r_queued <= r_queued + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_tail] <= iBus_rsp_instr;
            r_mem_pc[r_tail]    <= r_rsp_pc;
        end
    end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb/tb_ifetch_prefetch.sv - queue-level reference model and directed scenarios for ifetch_prefetch
module tb_ifetch_prefetch;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iBus_cmd_valid;
    logic        iBus_cmd_ready = 1'b0;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_valid = 1'b0;
    logic [31:0] iBus_rsp_instr = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] oPC;
    logic        branchTaken = 1'b0;
    logic [31:0] aluPC = 32'h0;

    ifetch_prefetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .iBus_cmd_valid(iBus_cmd_valid), .iBus_cmd_ready(iBus_cmd_ready),
        .iBus_cmd_payload_pc(iBus_cmd_payload_pc),
        .iBus_rsp_valid(iBus_rsp_valid), .iBus_rsp_instr(iBus_rsp_instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .oPC(oPC),
        .branchTaken(branchTaken), .aluPC(aluPC)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic rsp_en = 1'b0;

    logic [31:0] env_q[$];
    logic [31:0] fired[$];
    logic [31:0] deliv[$];

    logic        m_run;
    logic [31:0] m_pc;
    logic [31:0] m_ipc[$];
    logic        m_idrop[$];
    logic [31:0] m_qpc[$];
    logic [31:0] m_qin[$];

    function automatic logic [31:0] memf(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already set by the caller at the falling edge.
    task automatic tick();
        logic exp_v;
        logic fire;
        logic pop;
        logic [31:0] rpc;
        logic rdrop;
        iBus_rsp_valid = rsp_en && (env_q.size() > 0);
        iBus_rsp_instr = iBus_rsp_valid ? memf(env_q[0]) : 32'h0;
        #1;
        exp_v = m_run && ((m_qpc.size() + m_ipc.size()) < DEPTH)
                && (m_ipc.size() < MAXO) && !branchTaken;
        chk("cmd_valid", {31'b0, iBus_cmd_valid}, {31'b0, exp_v});
        if (exp_v) chk("cmd_pc", iBus_cmd_payload_pc, m_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, (m_qpc.size() > 0)});
        if (m_qpc.size() > 0) begin
            chk("instr", instr, m_qin[0]);
            chk("oPC", oPC, m_qpc[0]);
        end
        if (iBus_cmd_valid && iBus_cmd_ready) begin
            env_q.push_back(iBus_cmd_payload_pc);
            fired.push_back(iBus_cmd_payload_pc);
        end
        if (instr_valid && instr_ready) deliv.push_back(oPC);
        if (iBus_rsp_valid) void'(env_q.pop_front());

        fire = exp_v && iBus_cmd_ready;
        pop  = (m_qpc.size() > 0) && instr_ready;
        if (pop) begin
            void'(m_qpc.pop_front());
            void'(m_qin.pop_front());
        end
        if (iBus_rsp_valid && m_ipc.size() > 0) begin
            rpc   = m_ipc.pop_front();
            rdrop = m_idrop.pop_front();
            if (!rdrop && !branchTaken) begin
                m_qpc.push_back(rpc);
                m_qin.push_back(iBus_rsp_instr);
            end
        end
        if (branchTaken) begin
            m_qpc.delete();
            m_qin.delete();
            foreach (m_idrop[i]) m_idrop[i] = 1'b1;
            m_pc = aluPC & 32'hFFFF_FFFC;
        end else if (fire) begin
            m_ipc.push_back(m_pc);
            m_idrop.push_back(1'b0);
            m_pc = m_pc + 32'd4;
        end
        m_run = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        branchTaken = 1'b0;
        #1;
        chk("rst_cmd_valid", {31'b0, iBus_cmd_valid}, 32'h0);
        chk("rst_cmd_pc", iBus_cmd_payload_pc, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_oPC", oPC, 32'h0);
        @(posedge clk);
        @(negedge clk);
        env_q.delete(); fired.delete(); deliv.delete();
        m_ipc.delete(); m_idrop.delete(); m_qpc.delete(); m_qin.delete();
        m_run = 1'b0;
        m_pc  = 32'h0;
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        branchTaken = 1'b1;
        aluPC = tgt;
        tick();
        branchTaken = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        // Streaming fetch with single-cycle response latency
        do_reset();
        iBus_cmd_ready = 1'b1; rsp_en = 1'b1; instr_ready = 1'b1;
        ticks(12);
        chk("stream_fire0", fired[0], 32'h0);
        chk("stream_fire1", fired[1], 32'h4);
        chk("stream_fire2", fired[2], 32'h8);
        chk("stream_deliv0", deliv[0], 32'h0);
        chk("stream_deliv2", deliv[2], 32'h8);

        // Stalled consumer fills the queue, then redirect with concurrent pop
        do_reset();
        instr_ready = 1'b0;
        ticks(12);
        chk("full_accepts", fired.size(), 32'd4);
        chk("full_cmd_valid", {31'b0, iBus_cmd_valid}, 32'h0);
        chk("full_instr_valid", {31'b0, instr_valid}, 32'h1);
        chk("full_oPC", oPC, 32'h0);
        instr_ready = 1'b1;
        redirect(32'h200);
        chk("flush_empty", {31'b0, instr_valid}, 32'h0);
        ticks(8);

        // Command back-pressure holds the request
        do_reset();
        iBus_cmd_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'b0, iBus_cmd_valid}, 32'h1);
            chk("hold_pc", iBus_cmd_payload_pc, 32'h0);
            tick();
        end

        // Redirect with two in flight, no concurrent response
        do_reset();
        iBus_cmd_ready = 1'b1; rsp_en = 1'b0;
        redirect(32'h10);
        ticks(3);
        redirect(32'h103);
        chk("br_empty", {31'b0, instr_valid}, 32'h0);
        chk("br_next_pc", iBus_cmd_payload_pc, 32'h100);
        rsp_en = 1'b1;
        ticks(10);
        chk("br_first_oPC", deliv[0], 32'h100);

        // Redirect concurrent with a response
        do_reset();
        rsp_en = 1'b0;
        redirect(32'h20);
        ticks(3);
        rsp_en = 1'b1;
        redirect(32'h40);
        ticks(10);
        chk("brrsp_first_oPC", deliv[0], 32'h40);
        foreach (deliv[i]) begin
            if (deliv[i] == 32'h20 || deliv[i] == 32'h24) chk("brrsp_dropped", deliv[i], 32'h40);
        end

        // Address wrap at top of memory
        do_reset();
        redirect(32'hFFFF_FFFF);
        ticks(6);
        chk("wrap_fire0", fired[0], 32'hFFFF_FFFC);
        chk("wrap_fire1", fired[1], 32'h0000_0000);
        chk("wrap_deliv0", deliv[0], 32'hFFFF_FFFC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
